// File: rtl/simplerisc_ctrl.sv
// simplerisc_ctrl: multi-cycle control unit for the SimpleRISC core.
// Sequences FETCH -> DECODE -> EXECUTE -> (MEM) -> WB for each instruction.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   imem_req/addr/ack/rdata        instruction fetch handshake
//   dmem_req/we/ack                data access handshake (addr/data external)
//   alu_op, alu_flags              ALU operation code out, {gt,eq} flags in
//   rs1, rs2, rd, op2_imm, imm_out register addresses, operand-b select, immediate
//   ra_val                         current r15 contents (return address for ret)
//   rf_we, rf_waddr, rf_wsel       write-back strobe, address, source select
//   pc, illegal                    architectural PC, undefined-opcode pulse
module simplerisc_ctrl (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic [4:0]  alu_op,
  input  logic [1:0]  alu_flags,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [3:0]  rd,
  output logic        op2_imm,
  output logic [31:0] imm_out,
  input  logic [31:0] ra_val,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [1:0]  rf_wsel,
  output logic [31:0] pc,
  output logic        illegal
);

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB} state_t;

  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;
  localparam logic [4:0] OP_ILL0 = 5'b10101;

  state_t      state, state_nx;
  logic        run;        // low from reset until the first clock edge after release
  logic [31:0] ir;
  logic [1:0]  flags;      // {gt, eq} captured by cmp
  logic [4:0]  opcode;
  logic [31:0] imm_exp;
  logic [31:0] br_tgt;
  logic [31:0] pc_nx;
  logic        writes_rf;

  assign opcode = ir[31:27];

  // Immediate expansion; modifier 11 behaves like 00.
  always_comb begin
    imm_exp = {{16{ir[15]}}, ir[15:0]};
    case (ir[17:16])
      2'b01:   imm_exp = {16'h0000, ir[15:0]};
      2'b10:   imm_exp = {ir[15:0], 16'h0000};
      default: imm_exp = {{16{ir[15]}}, ir[15:0]};
    endcase
  end

  assign br_tgt = pc + {{3{ir[26]}}, ir[26:0], 2'b00};

  always_comb begin
    pc_nx = pc + 32'd4;
    case (opcode)
      OP_B, OP_CALL: pc_nx = br_tgt;
      OP_BEQ:        if (flags[0]) pc_nx = br_tgt;
      OP_BGT:        if (flags[1]) pc_nx = br_tgt;
      OP_RET:        pc_nx = ra_val;
      default:       pc_nx = pc + 32'd4;
    endcase
  end

  always_comb begin
    writes_rf = 1'b0;
    if (opcode <= 5'b01100 && opcode != OP_CMP) writes_rf = 1'b1;
    if (opcode == OP_LD || opcode == OP_CALL)    writes_rf = 1'b1;
  end

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH;
      run     <= 1'b0;
      pc      <= '0;
      ir      <= '0;
      flags   <= '0;
      rd      <= '0;
      rs1     <= '0;
      rs2     <= '0;
      imm_out <= '0;
      op2_imm <= 1'b0;
    end else begin
      state <= state_nx;
      run   <= 1'b1;
      case (state)
        FETCH:   if (run && imem_ack) ir <= imem_rdata;
        DECODE: begin
          rd      <= ir[25:22];
          rs1     <= ir[21:18];
          rs2     <= ir[17:14];
          imm_out <= imm_exp;
          op2_imm <= ir[26];
        end
        EXECUTE: if (opcode == OP_CMP) flags <= alu_flags;
        WB:      pc <= pc_nx;
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   if (run && imem_ack) state_nx = DECODE;
      DECODE:  state_nx = EXECUTE;
      EXECUTE: state_nx = (opcode == OP_LD || opcode == OP_ST) ? MEM : WB;
      MEM:     if (dmem_ack) state_nx = WB;
      WB:      state_nx = FETCH;
      default: state_nx = FETCH;
    endcase
  end

  // Outputs decoded from the registered state only
  always_comb begin
    imem_req  = (state == FETCH) && run;
    imem_addr = pc;
    dmem_req  = (state == MEM);
    dmem_we   = (state == MEM) && (opcode == OP_ST);
    alu_op    = OP_NOP;
    if ((state == EXECUTE || state == MEM) && !opcode[4]) alu_op = opcode;
    rf_we     = (state == WB) && writes_rf;
    rf_waddr  = (opcode == OP_CALL) ? 4'd15 : rd;
    rf_wsel   = 2'b00;
    if (opcode == OP_LD)   rf_wsel = 2'b01;
    if (opcode == OP_CALL) rf_wsel = 2'b10;
    illegal   = (state == WB) && (opcode >= OP_ILL0);
  end

endmodule
